// File: rtl/data_break_sequencer_pkg.sv
// Shared codes for the data-break sequencer: cycle types, DB phases, major states.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package data_break_sequencer_pkg;

    // Memory-cycle kind reported on cycle_type
    localparam logic [1:0] CT_NONE = 2'b00;
    localparam logic [1:0] CT_WC   = 2'b01;
    localparam logic [1:0] CT_CA   = 2'b10;
    localparam logic [1:0] CT_DATA = 2'b11;

    // Clock slot inside one three-clock memory cycle
    typedef enum logic [1:0] {
        PH_DB0 = 2'd0,
        PH_DB1 = 2'd1,
        PH_DB2 = 2'd2
    } phase_t;

    // Major-state encoding shared with the CPU state machine, so the value
    // handed back on return_state is directly loadable there.
    localparam int MS_W = 5;
    localparam logic [MS_W-1:0] MS_F0 = 5'd0;
    localparam logic [MS_W-1:0] MS_F1 = 5'd1;
    localparam logic [MS_W-1:0] MS_F2 = 5'd2;
    localparam logic [MS_W-1:0] MS_F3 = 5'd3;
    localparam logic [MS_W-1:0] MS_D0 = 5'd4;
    localparam logic [MS_W-1:0] MS_D1 = 5'd5;
    localparam logic [MS_W-1:0] MS_D2 = 5'd6;
    localparam logic [MS_W-1:0] MS_D3 = 5'd7;
    localparam logic [MS_W-1:0] MS_E0 = 5'd8;
    localparam logic [MS_W-1:0] MS_E1 = 5'd9;
    localparam logic [MS_W-1:0] MS_E2 = 5'd10;
    localparam logic [MS_W-1:0] MS_E3 = 5'd11;

    // Advance DB0 -> DB1 -> DB2; DB2 wraps to DB0 for the next memory cycle
    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_DB0:  return PH_DB1;
            PH_DB1:  return PH_DB2;
            default: return PH_DB0;
        endcase
    endfunction

endpackage

// File: rtl/data_break_sequencer_if.sv
// Bus between the CPU major-state machine and the data-break sequencer.
// Latency: n/a (wires only).
// Backpressure: none; boundary is a one-clock offer, break_req is a held level.
interface data_break_sequencer_if #(
    parameter int NCH     = 2,
    parameter int STATE_W = 5
);
    logic               boundary;
    logic [STATE_W-1:0] resume_state;
    logic [NCH-1:0]     break_req;
    logic [NCH-1:0]     three_cycle;
    logic [0:11]        mem_rdata;

    logic               take_break;
    logic               break_in_prog;
    logic [NCH-1:0]     grant;
    logic [1:0]         cycle_type;
    logic [1:0]         phase;
    logic [0:11]        wb_data;
    logic               wb_en;
    logic [NCH-1:0]     wc_ovf;
    logic               done;
    logic [STATE_W-1:0] return_state;

    // CPU / datapath side
    modport master (
        output boundary, resume_state, break_req, three_cycle, mem_rdata,
        input  take_break, break_in_prog, grant, cycle_type, phase,
               wb_data, wb_en, wc_ovf, done, return_state
    );

    // Sequencer side
    modport slave (
        input  boundary, resume_state, break_req, three_cycle, mem_rdata,
        output take_break, break_in_prog, grant, cycle_type, phase,
               wb_data, wb_en, wc_ovf, done, return_state
    );
endinterface

// File: rtl/data_break_sequencer_break_arbiter.sv
// Picks one requesting channel: lowest index, or first at/after a rotating pointer.
// Latency: combinational grant; pointer updates on the clock after grant_en.
// Backpressure: none; caller decides when a grant is taken via grant_en.
module break_arbiter #(
    parameter int NCH         = 2,
    parameter int ROUND_ROBIN = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic           grant_en,
    output logic [NCH-1:0] gnt
);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] sel;
    logic             found;
    int               base;
    int               idx;

    // Circular scan starting at base; base is 0 under fixed priority
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = '0;
        idx     = 0;
        base    = (ROUND_ROBIN != 0) ? int'(ptr) : 0;
        for (int i = 0; i < NCH; i++) begin
            idx = base + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                found     = 1'b1;
                gnt[sel]  = 1'b1;
                gnt_idx   = sel;
            end
        end
    end

    // Rotate pointer to the channel after the one just granted
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_en && found) begin
            ptr <= (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/data_break_sequencer.sv
// Multi-channel data-break sequencer: WC/CA/DATA or DATA-only cycles inserted at CPU boundaries.
// Latency: first DB0 one clock after the accepted boundary; 3 clocks per memory cycle.
// Backpressure: none; requests wait (held level) until a boundary finds the sequencer idle.
module data_break_sequencer
    import data_break_sequencer_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int STATE_W     = 5,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_BURST   = 1
) (
    input  logic clk,
    input  logic reset,
    data_break_sequencer_if.slave bus
);
    // Sequencer state doubles as the reported cycle type
    typedef enum logic [1:0] {
        S_IDLE = CT_NONE,
        S_WC   = CT_WC,
        S_CA   = CT_CA,
        S_DATA = CT_DATA
    } state_t;

    state_t             state;
    phase_t             phase;
    logic [NCH-1:0]     grant;
    logic [0:11]        wb_data;
    logic               wb_en;
    logic [NCH-1:0]     wc_ovf;
    logic [STATE_W-1:0] return_state;
    logic [2:0]         burst_cnt;

    logic [NCH-1:0]     arb_gnt;
    logic               take_break;
    logic               data_last;
    logic               chain;
    logic               arb_take;
    logic               next_three;
    logic [0:11]        wb_next;

    // Accept a break only from IDLE, on a boundary, with someone asking
    assign take_break = bus.boundary && (|bus.break_req) && (state == S_IDLE);

    // Final clock of a DATA cycle decides between chaining and handing back
    assign data_last  = (state == S_DATA) && (phase == PH_DB2);
    assign chain      = data_last && (burst_cnt < 3'(MAX_BURST - 1)) && (|bus.break_req);
    assign arb_take   = take_break || chain;
    assign next_three = |(bus.three_cycle & arb_gnt);
    assign wb_next    = bus.mem_rdata + 12'd1;

    break_arbiter #(
        .NCH         (NCH),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.break_req),
        .grant_en (arb_take),
        .gnt      (arb_gnt)
    );

    // Break-sequence FSM: IDLE -> [WC -> CA ->] DATA, three phases per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            phase        <= PH_DB0;
            grant        <= '0;
            wb_data      <= '0;
            wb_en        <= 1'b0;
            wc_ovf       <= '0;
            return_state <= '0;
            burst_cnt    <= '0;
        end else begin
            wb_en  <= 1'b0;
            wc_ovf <= '0;
            case (state)
                S_IDLE: begin
                    if (take_break) begin
                        return_state <= bus.resume_state;
                        grant        <= arb_gnt;
                        burst_cnt    <= '0;
                        phase        <= PH_DB0;
                        state        <= next_three ? S_WC : S_DATA;
                    end
                end
                S_WC, S_CA: begin
                    // Increment lands in DB1 so the write-back is ready for DB2
                    if (phase == PH_DB1) begin
                        wb_data <= wb_next;
                        wb_en   <= 1'b1;
                        if ((state == S_WC) && (wb_next == 12'd0)) begin
                            wc_ovf <= grant;
                        end
                    end
                    phase <= next_phase(phase);
                    if (phase == PH_DB2) begin
                        state <= (state == S_WC) ? S_CA : S_DATA;
                    end
                end
                default: begin
                    phase <= next_phase(phase);
                    if (phase == PH_DB2) begin
                        if (chain) begin
                            grant     <= arb_gnt;
                            burst_cnt <= burst_cnt + 3'd1;
                            state     <= next_three ? S_WC : S_DATA;
                        end else begin
                            grant     <= '0;
                            burst_cnt <= '0;
                            state     <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.take_break    = take_break;
    assign bus.break_in_prog = (state != S_IDLE);
    assign bus.grant         = grant;
    assign bus.cycle_type    = state;
    assign bus.phase         = phase;
    assign bus.wb_data       = wb_data;
    assign bus.wb_en         = wb_en;
    assign bus.wc_ovf        = wc_ovf;
    assign bus.done          = data_last && !chain;
    assign bus.return_state  = return_state;

endmodule

// File: tb/tb_data_break_sequencer.sv
// Directed bench: three sequencer variants (fixed, round-robin, burst-of-2) on shared stimulus.
// Latency: inputs driven on the falling edge, outputs checked 1 time unit later.
// Backpressure: n/a.
module tb_data_break_sequencer;
    import data_break_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        boundary = 1'b0;
    logic [4:0]  resume_state = '0;
    logic [1:0]  break_req = '0;
    logic [1:0]  three_cycle = '0;
    logic [0:11] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_break_sequencer_if #(.NCH(2), .STATE_W(5)) if_f ();
    data_break_sequencer_if #(.NCH(2), .STATE_W(5)) if_r ();
    data_break_sequencer_if #(.NCH(2), .STATE_W(5)) if_m ();

    assign if_f.boundary = boundary;  assign if_r.boundary = boundary;  assign if_m.boundary = boundary;
    assign if_f.resume_state = resume_state;
    assign if_r.resume_state = resume_state;
    assign if_m.resume_state = resume_state;
    assign if_f.break_req = break_req;  assign if_r.break_req = break_req;  assign if_m.break_req = break_req;
    assign if_f.three_cycle = three_cycle;
    assign if_r.three_cycle = three_cycle;
    assign if_m.three_cycle = three_cycle;
    assign if_f.mem_rdata = mem_rdata;  assign if_r.mem_rdata = mem_rdata;  assign if_m.mem_rdata = mem_rdata;

    data_break_sequencer #(.NCH(2), .STATE_W(5), .ROUND_ROBIN(0), .MAX_BURST(1)) u_fix (
        .clk(clk), .reset(reset), .bus(if_f.slave));
    data_break_sequencer #(.NCH(2), .STATE_W(5), .ROUND_ROBIN(1), .MAX_BURST(1)) u_rr (
        .clk(clk), .reset(reset), .bus(if_r.slave));
    data_break_sequencer #(.NCH(2), .STATE_W(5), .ROUND_ROBIN(0), .MAX_BURST(2)) u_mb (
        .clk(clk), .reset(reset), .bus(if_m.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, let combinational outputs settle
    task automatic drv(input logic b, input logic [4:0] rs, input logic [1:0] rq,
                       input logic [1:0] tc, input logic [11:0] rd);
        @(negedge clk);
        boundary     = b;
        resume_state = rs;
        break_req    = rq;
        three_cycle  = tc;
        mem_rdata    = rd;
        #1;
    endtask

    task automatic rst();
        @(negedge clk);
        reset = 1'b1;
        boundary = 1'b0; break_req = '0; three_cycle = '0; mem_rdata = '0; resume_state = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // ---- reset state
        rst();
        #1;
        chk("rst_bip",   if_f.break_in_prog, 0);
        chk("rst_grant", if_f.grant, 0);
        chk("rst_ct",    if_f.cycle_type, 0);
        chk("rst_phase", if_f.phase, 0);
        chk("rst_wben",  if_f.wb_en, 0);
        chk("rst_done",  if_f.done, 0);
        chk("rst_ret",   if_f.return_state, 0);

        // ---- single-cycle channel 0, resume E0
        drv(1, MS_E0, 2'b01, 2'b00, 12'o0);
        chk("t1_take", if_f.take_break, 1);
        drv(0, MS_E0, 2'b01, 2'b00, 12'o0);
        chk("t1_ct0", if_f.cycle_type, CT_DATA);
        chk("t1_ph0", if_f.phase, 0);
        chk("t1_gnt", if_f.grant, 2'b01);
        chk("t1_bip", if_f.break_in_prog, 1);
        chk("t1_done0", if_f.done, 0);
        drv(0, MS_E0, 2'b01, 2'b00, 12'o0);
        chk("t1_ph1", if_f.phase, 1);
        drv(0, MS_E0, 2'b01, 2'b00, 12'o0);
        chk("t1_ph2", if_f.phase, 2);
        chk("t1_done", if_f.done, 1);
        chk("t1_ret", if_f.return_state, MS_E0);
        drv(0, MS_E0, 2'b00, 2'b00, 12'o0);
        chk("t1_idle_bip", if_f.break_in_prog, 0);
        chk("t1_idle_gnt", if_f.grant, 0);
        chk("t1_idle_ct", if_f.cycle_type, CT_NONE);
        chk("t1_idle_done", if_f.done, 0);

        // ---- three-cycle channel 0: WC 7777 overflows, CA 0200 -> 0201
        drv(1, MS_D0, 2'b01, 2'b01, 12'o7777);
        chk("t2_take", if_f.take_break, 1);
        drv(0, MS_D0, 2'b01, 2'b01, 12'o7777);
        chk("t2_wc_ct", if_f.cycle_type, CT_WC);
        chk("t2_wc_ph0", if_f.phase, 0);
        drv(0, MS_D0, 2'b01, 2'b01, 12'o7777);
        chk("t2_wc_ph1", if_f.phase, 1);
        chk("t2_wc_wben1", if_f.wb_en, 0);
        drv(0, MS_D0, 2'b01, 2'b01, 12'o0200);
        chk("t2_wc_ph2", if_f.phase, 2);
        chk("t2_wc_wben", if_f.wb_en, 1);
        chk("t2_wc_wbd", if_f.wb_data, 12'o0000);
        chk("t2_wc_ovf", if_f.wc_ovf, 2'b01);
        drv(0, MS_D0, 2'b01, 2'b01, 12'o0200);
        chk("t2_ca_ct", if_f.cycle_type, CT_CA);
        chk("t2_ca_wben0", if_f.wb_en, 0);
        chk("t2_ca_ovf0", if_f.wc_ovf, 0);
        drv(0, MS_D0, 2'b00, 2'b01, 12'o0200);
        chk("t2_ca_ph1", if_f.phase, 1);
        drv(0, MS_D0, 2'b00, 2'b01, 12'o0200);
        chk("t2_ca_wben", if_f.wb_en, 1);
        chk("t2_ca_wbd", if_f.wb_data, 12'o0201);
        chk("t2_ca_ovf", if_f.wc_ovf, 0);
        drv(0, MS_D0, 2'b00, 2'b01, 12'o0);
        chk("t2_data_ct", if_f.cycle_type, CT_DATA);
        chk("t2_data_wben", if_f.wb_en, 0);
        drv(0, MS_D0, 2'b00, 2'b01, 12'o0);
        chk("t2_data_ph1", if_f.phase, 1);
        drv(0, MS_D0, 2'b00, 2'b01, 12'o0);
        chk("t2_done", if_f.done, 1);
        chk("t2_ret", if_f.return_state, MS_D0);
        drv(0, MS_D0, 2'b00, 2'b00, 12'o0);
        chk("t2_idle", if_f.break_in_prog, 0);

        // ---- simultaneous requests: fixed, rotate, and burst of two
        rst();
        drv(1, MS_E2, 2'b11, 2'b00, 12'o0);
        chk("t3_take_f", if_f.take_break, 1);
        chk("t3_take_m", if_m.take_break, 1);
        drv(0, MS_E2, 2'b11, 2'b00, 12'o0);
        chk("t3_gnt_f", if_f.grant, 2'b01);
        chk("t3_gnt_r", if_r.grant, 2'b01);
        chk("t3_gnt_m", if_m.grant, 2'b01);
        drv(0, MS_E2, 2'b11, 2'b00, 12'o0);
        drv(0, MS_E2, 2'b11, 2'b00, 12'o0);
        chk("t3_done_f", if_f.done, 1);
        chk("t3_done_m", if_m.done, 0);
        chk("t3_bip_m2", if_m.break_in_prog, 1);
        drv(0, MS_E2, 2'b11, 2'b00, 12'o0);
        chk("t3_bip_f", if_f.break_in_prog, 0);
        chk("t3_bip_m", if_m.break_in_prog, 1);
        chk("t3_gnt_m2", if_m.grant, 2'b01);
        chk("t3_ph_m2", if_m.phase, 0);
        chk("t3_ct_m2", if_m.cycle_type, CT_DATA);
        drv(1, MS_D1, 2'b11, 2'b00, 12'o0);
        chk("t3_take_f2", if_f.take_break, 1);
        chk("t3_take_r2", if_r.take_break, 1);
        chk("t3_take_busy", if_m.take_break, 0);
        drv(0, MS_D1, 2'b11, 2'b00, 12'o0);
        chk("t3_gnt_r2", if_r.grant, 2'b10);
        chk("t3_gnt_f2", if_f.grant, 2'b01);
        chk("t3_done_m2", if_m.done, 1);
        chk("t3_ret_m", if_m.return_state, MS_E2);
        drv(0, MS_D1, 2'b00, 2'b00, 12'o0);
        chk("t3_idle_m", if_m.break_in_prog, 0);
        chk("t3_idle_gm", if_m.grant, 0);
        drv(0, MS_D1, 2'b00, 2'b00, 12'o0);
        chk("t3_done_f2", if_f.done, 1);
        chk("t3_ret_f2", if_f.return_state, MS_D1);
        drv(0, MS_D1, 2'b00, 2'b00, 12'o0);
        chk("t3_idle_f", if_f.break_in_prog, 0);

        // ---- reset in CA DB1 abandons the sequence
        rst();
        drv(1, MS_F2, 2'b01, 2'b01, 12'o0005);
        drv(0, MS_F2, 2'b01, 2'b01, 12'o0005);
        drv(0, MS_F2, 2'b01, 2'b01, 12'o0005);
        drv(0, MS_F2, 2'b01, 2'b01, 12'o0005);
        chk("t4_wc_wbd", if_f.wb_data, 12'o0006);
        drv(0, MS_F2, 2'b01, 2'b01, 12'o0005);
        drv(0, MS_F2, 2'b01, 2'b01, 12'o0005);
        chk("t4_ca_ct", if_f.cycle_type, CT_CA);
        chk("t4_ca_ph1", if_f.phase, 1);
        reset = 1'b1;
        drv(0, MS_F2, 2'b00, 2'b00, 12'o0);
        chk("t4_rst_bip", if_f.break_in_prog, 0);
        chk("t4_rst_gnt", if_f.grant, 0);
        chk("t4_rst_ct", if_f.cycle_type, 0);
        chk("t4_rst_ph", if_f.phase, 0);
        chk("t4_rst_wben", if_f.wb_en, 0);
        chk("t4_rst_wbd", if_f.wb_data, 0);
        chk("t4_rst_done", if_f.done, 0);
        chk("t4_rst_ret", if_f.return_state, 0);
        reset = 1'b0;
        drv(1, MS_F3, 2'b01, 2'b00, 12'o0);
        chk("t4_take", if_f.take_break, 1);
        drv(0, MS_F3, 2'b00, 2'b00, 12'o0);
        chk("t4_gnt", if_f.grant, 2'b01);
        chk("t4_ct", if_f.cycle_type, CT_DATA);
        chk("t4_ph", if_f.phase, 0);
        drv(0, MS_F3, 2'b00, 2'b00, 12'o0);
        drv(0, MS_F3, 2'b00, 2'b00, 12'o0);
        chk("t4_done", if_f.done, 1);
        chk("t4_ret", if_f.return_state, MS_F3);

        // ---- boundary with no request
        drv(1, MS_E1, 2'b00, 2'b00, 12'o0);
        chk("t5_take", if_f.take_break, 0);
        drv(0, MS_E1, 2'b00, 2'b00, 12'o0);
        chk("t5_bip", if_f.break_in_prog, 0);
        chk("t5_ct", if_f.cycle_type, CT_NONE);
        chk("t5_gnt", if_f.grant, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_break_sequencer.md
Name: data_break_sequencer

Overview:
Multi-channel data-break (DMA) sequencer for the PDP-8/E core. It generalises the major-state machine's single-source DB0–DB2 break path to NCH prioritised channels. Each channel may request either single-cycle or three-cycle breaks; three-cycle breaks perform the word-count (WC) and current-address (CA) memory updates. The major-state machine offers a cycle boundary, hands over the state it was about to enter, and gets that state back when the break sequence finishes.

Parameters:
NCH, 2, number of break channels (1..8); channel 0 has highest priority.
STATE_W, 5, width of the major-state encoding carried through resume/return.
ROUND_ROBIN, 0, 0 = fixed priority; 1 = rotate priority, starting after the last granted channel.
MAX_BURST, 1, maximum breaks chained back-to-back before control returns to the CPU (1..4).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
boundary  in  1  one-clock pulse at F3/D3/E3 when a break may be inserted
resume_state  in  STATE_W  state the CPU would enter next; valid with boundary
break_req  in  NCH  level request per channel; held until served
three_cycle  in  NCH  per-channel mode: 1 = WC/CA/data sequence, 0 = data only
mem_rdata  in  [0:11]  memory read data during a WC or CA cycle
take_break  out  1  combinational: boundary & any request & idle
break_in_prog  out  1  high for every clock of a break sequence
grant  out  NCH  one-hot channel being served; zero when idle
cycle_type  out  2  00 none, 01 WC, 10 CA, 11 DATA
phase  out  2  0/1/2 = DB0/DB1/DB2 within the current cycle
wb_data  out  [0:11]  mem_rdata + 1, registered in DB1
wb_en  out  1  memory write-back strobe during DB2 of WC/CA cycles
wc_ovf  out  NCH  one-clock pulse: the incremented WC wrapped to 0000
done  out  1  one-clock pulse on the last DB2 of the sequence
return_state  out  STATE_W  latched resume_state; valid while done is high

Behaviour:
- Reset: all outputs 0; FSM in IDLE; round-robin pointer = 0; burst counter = 0. A reset mid-break abandons the sequence immediately, with no wb_en and no done.
- IDLE with boundary & |break_req:
  - latch resume_state;
  - arbitrate and latch grant and three_cycle[ch];
  - on the next clock enter WC (if three_cycle) else DATA, with phase 0 and break_in_prog = 1.
- IDLE with boundary and no request: no action, take_break = 0.
- Each memory cycle lasts exactly 3 clocks (phase 0, 1, 2).
  - Sequence is WC → CA → DATA for three-cycle channels; DATA only otherwise.
  - Break latency from boundary to the first DB0 clock is 1 clock.
- WC/CA cycles:
  - DB1 registers wb_data = mem_rdata + 1 (12-bit, 7777 wraps to 0000).
  - DB2 asserts wb_en.
  - WC only: if wb_data == 0000, wc_ovf[ch] pulses in DB2. The channel still completes its DATA cycle.
- DATA cycle: grant identifies the channel; the datapath performs the transfer. The sequencer issues no write-back.
- End of DATA DB2:
  - If the burst count < MAX_BURST and a request is present (re-arbitrated, including the just-served channel under fixed priority), start the next sequence on the following clock. break_in_prog stays high.
  - Otherwise pulse done with return_state, clear break_in_prog, grant and cycle_type, and return to IDLE.
- The burst counter clears on return to IDLE.
- break_req changes during a sequence do not alter the current grant. Dropping a request mid-sequence still completes that sequence.
- boundary pulses while not IDLE are ignored; take_break = 0 in that case.
- ROUND_ROBIN = 1: the pointer advances to granted+1 mod NCH at each grant.
- Simultaneous requests: the lowest index wins (fixed), or the first index at or after the pointer (rotate).

Decomposition:
- Shared package constants:
  - cycle_type codes (CT_NONE, CT_WC, CT_CA, CT_DATA);
  - phase codes DB0–DB2;
  - the major-state encoding, so return_state matches the state machine.
- One sub-module: break_arbiter, a combinational priority/rotate selector with a registered pointer, parametrised by NCH and ROUND_ROBIN.

Test Plan:
- NCH=2, req[0]=1, three_cycle=0, boundary with resume_state=E0 → take_break=1 that clock; 3 clocks of DATA phases 0/1/2 with grant=01; done with return_state=E0; total 4 clocks to IDLE.
- Three-cycle channel, mem_rdata=7777 in the WC cycle and 0200 in the CA cycle → wb_data 0000 then 0201; wc_ovf[0] pulses in the WC DB2; the DATA cycle still runs; 9 break clocks.
- req=11 simultaneous, fixed priority → grant 01 first. With ROUND_ROBIN=1 over two boundaries → grants 01 then 10.
- MAX_BURST=2, req=11 held → two chained DATA cycles (6 clocks) with break_in_prog continuously high, then done.
- reset asserted in phase 1 of CA → next clock all outputs 0, no wb_en, no done. A subsequent boundary with a request restarts normally.
- boundary without requests, and boundary during a break → take_break=0 and no state change.
